// File: rtl/dot_accum_pkg.sv
// Shared types and defaults for the dot-product accumulator.
package dot_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int PROD_W_DEF = 8;

endpackage

// File: rtl/dot_accum.sv
// Sums N_TERMS unsigned products from an upstream multiplier and holds the
// result until the downstream consumer takes it.
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = PROD_W + $clog2(N_TERMS),
    localparam int CNT_W  = $clog2(N_TERMS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] term_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

    // Handshake flags depend on state only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign term_cnt  = cnt_q;

    assign xfer = in_valid && in_ready && !clr;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        // First term of a group overwrites rather than adds.
                        acc_d = (cnt_q == '0) ? ACC_W'(in_prod)
                                              : acc_q + ACC_W'(in_prod);
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 Parameter N_TERMS, default 4, is the number of products summed per result; it SHALL be at least 2.
REQ-002 Parameter PROD_W, default 8, is the product width and SHALL match the multiplier result width.
REQ-003 Parameter ACC_W, default PROD_W+$clog2(N_TERMS) (10), is the sum width.
REQ-004 The clock and reset ports SHALL be as follows.
- clk, input, 1 bit: the single clock; all state changes on its rising edge.
- rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The upstream (product) ports SHALL be as follows.
- clr, input, 1 bit: synchronous abort of the current accumulation.
- in_valid, input, 1 bit: upstream product valid.
- in_ready, output, 1 bit: block accepts a product.
- in_prod, input, PROD_W bits: unsigned product from the multiplier.
REQ-006 The downstream (result) ports SHALL be as follows.
- out_valid, output, 1 bit: result valid.
- out_ready, input, 1 bit: downstream accepts the result.
- out_sum, output, ACC_W bits: unsigned dot-product result.
- term_cnt, output, $clog2(N_TERMS)+1 bits: number of products accepted in the current group.

Function
REQ-007 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-008 In ACCUM, the block SHALL drive in_ready=1 and out_valid=0.
REQ-009 In HOLD, the block SHALL drive in_ready=0 and out_valid=1.
REQ-010 An input transfer SHALL occur on a cycle where in_valid and in_ready are both 1; no other cycle SHALL change the accumulator.
REQ-011 On a transfer with term_cnt=0, acc SHALL become zero-extended in_prod; on any other transfer, acc SHALL become acc+in_prod; term_cnt SHALL increment on every transfer.
REQ-012 When the transfer that makes term_cnt reach N_TERMS occurs, the FSM SHALL move to HOLD, so out_valid rises the cycle after the last accepted product.
REQ-013 In HOLD, out_sum and term_cnt SHALL remain stable until out_ready=1.
REQ-014 On the HOLD cycle with out_ready=1, the FSM SHALL return to ACCUM, term_cnt SHALL become 0, and in_ready SHALL be 1 on the next cycle.
REQ-015 The sum SHALL be computed in ACC_W bits, which cannot overflow for unsigned inputs (worst case N_TERMS*(2^PROD_W-1)).
REQ-016 out_sum SHALL equal acc in every state; its value outside HOLD carries no meaning.
REQ-017 in_valid=0 gaps during ACCUM SHALL pause accumulation without loss of the partial sum.
REQ-018 clr=1 SHALL set acc=0 and term_cnt=0 and put the FSM in ACCUM, discarding any partial sum or held result; a product presented in the same cycle SHALL NOT be accepted.
REQ-019 When rst=1 and clr=1 in the same cycle, rst SHALL take priority; the outcome is identical.
REQ-020 No combinational path SHALL exist from out_ready to in_ready.

Reset
REQ-021 While rst=1, on each clk edge: state=ACCUM, acc=0, term_cnt=0.
REQ-022 Outputs during reset SHALL be in_ready=1, out_valid=0, out_sum=0, term_cnt=0.
REQ-023 Reset asserted mid-group or in HOLD SHALL discard all data, with no result emitted.

Structure
REQ-024 A package dot_accum_pkg SHALL hold the state enum (ACCUM, HOLD) and the PROD_W default constant.
REQ-025 No sub-module SHALL be used; the counter, adder and FSM are inline. The multiplier SHALL sit upstream, outside this block.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Basic: products 10, 6, 35, 14 back-to-back, out_ready=1 -> out_valid=1 for one cycle, one cycle after the 4th accept, out_sum=65.
- Max: four products of 225 -> out_sum=900 with no wrap; term_cnt=4 in HOLD.
- Backpressure: out_ready held 0 for 3 cycles in HOLD -> out_sum stable, in_ready=0, no input accepted; release -> accept resumes the next cycle.
- Gaps: products 1, 2, 3, 4 with in_valid idle cycles between them -> out_sum=10.
- clr: accept 50, 60, then assert clr with in_valid=1 and value 99 -> 99 not taken; next group 1, 2, 3, 4 -> out_sum=10.
- Reset mid-group: rst after 2 accepts -> all outputs at reset values; next group 5, 5, 5, 5 -> out_sum=20.
